// File: rtl/wb_stage_if.sv
// Bundle between the MEM stage, the WB stage and decode.
// The master side drives the MEM-stage slot and the stall/flush controls;
// the slave side (wb_stage) returns the write-back port and status.
// retire_cnt exists only when WB_RETIRE_CNT_EN is defined.
interface wb_stage_if;
   logic        mem_valid;
   logic        mem_regWrite;
   logic [2:0]  mem_write_reg;
   logic [1:0]  mem_memToReg;
   logic [15:0] mem_alu_res;
   logic [15:0] mem_read_data;
   logic [15:0] mem_pc_inc;
   logic        mem_halt;
   logic        mem_rd_pending;
   logic        mem_rd_done;
   logic        stall;
   logic        flush;

   logic        wb_regWrite;
   logic [2:0]  wb_write_reg;
   logic [15:0] mem_write_back;
   logic        wb_stall_req;
   logic        halted;
   logic        wb_err;
`ifdef WB_RETIRE_CNT_EN
   logic [15:0] retire_cnt;
`endif

   modport master (
      output mem_valid, mem_regWrite, mem_write_reg, mem_memToReg,
             mem_alu_res, mem_read_data, mem_pc_inc, mem_halt,
             mem_rd_pending, mem_rd_done, stall, flush,
      input  wb_regWrite, wb_write_reg, mem_write_back, wb_stall_req,
             halted, wb_err
`ifdef WB_RETIRE_CNT_EN
      , input retire_cnt
`endif
   );

   modport slave (
      input  mem_valid, mem_regWrite, mem_write_reg, mem_memToReg,
             mem_alu_res, mem_read_data, mem_pc_inc, mem_halt,
             mem_rd_pending, mem_rd_done, stall, flush,
      output wb_regWrite, wb_write_reg, mem_write_back, wb_stall_req,
             halted, wb_err
`ifdef WB_RETIRE_CNT_EN
      , output retire_cnt
`endif
   );
endinterface

// File: rtl/wb_stage.sv
// Write-back pipeline stage: WB register, write-back source select,
// wait for late load data, and sticky halt.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------
// RUN      | normal operation, WB register captures from MEM
// WAIT_MEM | load in WB waiting for mem_rd_done, upstream stalled
// HALTED   | HALT retired, everything frozen until rst
module wb_stage (
   input  logic        clk,
   input  logic        rst,
   wb_stage_if.slave   bus
);
   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] WAIT_MEM = 2'd1;
   localparam logic [1:0] HALTED   = 2'd2;

   logic [1:0]  state;
   logic        valid_q;
   logic        reg_write_q;
   logic [2:0]  write_reg_q;
   logic [1:0]  mem_to_reg_q;
   logic [15:0] alu_q;
   logic [15:0] data_q;
   logic [15:0] pc_inc_q;
   logic        halt_q;
   logic        first_q;
   logic        active;
   logic        take;
   logic        go_wait;

   // Fields of an incoming bubble are zeroed so stale values never reach decode
   assign take    = bus.mem_valid;
   assign go_wait = bus.mem_valid && (bus.mem_memToReg == 2'b01)
                    && bus.mem_rd_pending && !bus.mem_rd_done;

   // WB register and state machine
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= 3'd0;
         mem_to_reg_q <= 2'b00;
         alu_q        <= 16'h0000;
         data_q       <= 16'h0000;
         pc_inc_q     <= 16'h0000;
         halt_q       <= 1'b0;
         first_q      <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (valid_q && halt_q) begin
                  state   <= HALTED;
                  first_q <= 1'b0;
               end else if (bus.flush) begin
                  valid_q      <= 1'b0;
                  reg_write_q  <= 1'b0;
                  write_reg_q  <= 3'd0;
                  mem_to_reg_q <= 2'b00;
                  alu_q        <= 16'h0000;
                  data_q       <= 16'h0000;
                  pc_inc_q     <= 16'h0000;
                  halt_q       <= 1'b0;
                  first_q      <= 1'b0;
               end else if (!bus.stall) begin
                  valid_q      <= take;
                  reg_write_q  <= take & bus.mem_regWrite;
                  write_reg_q  <= take ? bus.mem_write_reg : 3'd0;
                  mem_to_reg_q <= take ? bus.mem_memToReg : 2'b00;
                  alu_q        <= take ? bus.mem_alu_res : 16'h0000;
                  data_q       <= take ? bus.mem_read_data : 16'h0000;
                  pc_inc_q     <= take ? bus.mem_pc_inc : 16'h0000;
                  halt_q       <= take & bus.mem_halt;
                  first_q      <= 1'b1;
                  if (go_wait) state <= WAIT_MEM;
               end else begin
                  first_q <= 1'b0;
               end
            end
            WAIT_MEM: begin
               // first_q re-armed so the load writes exactly once on return
               if (bus.mem_rd_done) begin
                  data_q  <= bus.mem_read_data;
                  first_q <= 1'b1;
                  state   <= RUN;
               end
            end
            HALTED: begin
               first_q <= 1'b0;
            end
            default: state <= RUN;
         endcase
      end
   end

   // Instruction completes WB in its first RUN cycle
   assign active = valid_q && first_q && (state == RUN);

   // Write-back source select and status outputs
   always_comb begin
      bus.mem_write_back = 16'h0000;
      case (mem_to_reg_q)
         2'b00:   bus.mem_write_back = alu_q;
         2'b01:   bus.mem_write_back = data_q;
         2'b10:   bus.mem_write_back = pc_inc_q;
         default: bus.mem_write_back = 16'h0000;
      endcase
   end

   assign bus.wb_regWrite  = active && reg_write_q;
   assign bus.wb_write_reg = write_reg_q;
   assign bus.wb_err       = active && (mem_to_reg_q == 2'b11);
   assign bus.wb_stall_req = (state != RUN);
   assign bus.halted       = (state == HALTED);

`ifdef WB_RETIRE_CNT_EN
   logic [15:0] retire_q;

   // Saturating count of retired valid instructions
   always_ff @(posedge clk) begin
      if (rst)
         retire_q <= 16'h0000;
      else if (active && (retire_q != 16'hFFFF))
         retire_q <= retire_q + 16'd1;
   end

   assign bus.retire_cnt = retire_q;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_wb_stage;
   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   wb_stage_if bus ();

   wb_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_cnt(input string tag, input logic [15:0] exp);
`ifdef WB_RETIRE_CNT_EN
      check(tag, bus.retire_cnt, exp);
`else
      if (exp == 16'hFFFF) $display("note %s", tag);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.mem_valid      = 1'b0;
      bus.mem_regWrite   = 1'b0;
      bus.mem_write_reg  = 3'd0;
      bus.mem_memToReg   = 2'b00;
      bus.mem_alu_res    = 16'h0000;
      bus.mem_read_data  = 16'h0000;
      bus.mem_pc_inc     = 16'h0000;
      bus.mem_halt       = 1'b0;
      bus.mem_rd_pending = 1'b0;
      bus.mem_rd_done    = 1'b0;
      bus.stall          = 1'b0;
      bus.flush          = 1'b0;
   endtask

   task automatic instr(input logic [2:0] rd, input logic [1:0] m2r, input logic [15:0] alu);
      idle();
      bus.mem_valid     = 1'b1;
      bus.mem_regWrite  = 1'b1;
      bus.mem_write_reg = rd;
      bus.mem_memToReg  = m2r;
      bus.mem_alu_res   = alu;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step(); step();
      check("rst_regwrite", {15'd0, bus.wb_regWrite}, 16'd0);
      check("rst_write_reg", {13'd0, bus.wb_write_reg}, 16'd0);
      check("rst_wb_data", bus.mem_write_back, 16'h0000);
      check("rst_stall_req", {15'd0, bus.wb_stall_req}, 16'd0);
      check("rst_halted", {15'd0, bus.halted}, 16'd0);
      check("rst_err", {15'd0, bus.wb_err}, 16'd0);
      check_cnt("rst_cnt", 16'd0);
      rst = 1'b0;

      // ALU op to r3
      instr(3'd3, 2'b00, 16'h1234);
      step();
      check("alu_regwrite", {15'd0, bus.wb_regWrite}, 16'd1);
      check("alu_write_reg", {13'd0, bus.wb_write_reg}, 16'd3);
      check("alu_data", bus.mem_write_back, 16'h1234);
      idle();
      step();
      check("alu_one_cycle", {15'd0, bus.wb_regWrite}, 16'd0);
      check_cnt("alu_cnt", 16'd1);

      // PC+2 source to r1
      instr(3'd1, 2'b10, 16'h9999);
      bus.mem_pc_inc = 16'h0042;
      step();
      check("pc_data", bus.mem_write_back, 16'h0042);
      check("pc_regwrite", {15'd0, bus.wb_regWrite}, 16'd1);

      // Stall held for two cycles on a writing instruction
      instr(3'd4, 2'b00, 16'h00AA);
      step();
      check("stall_first_write", {15'd0, bus.wb_regWrite}, 16'd1);
      instr(3'd6, 2'b00, 16'h5555);
      bus.stall = 1'b1;
      step();
      check("stall_no_rewrite1", {15'd0, bus.wb_regWrite}, 16'd0);
      check("stall_hold_reg", {13'd0, bus.wb_write_reg}, 16'd4);
      check("stall_hold_data", bus.mem_write_back, 16'h00AA);
      step();
      check("stall_no_rewrite2", {15'd0, bus.wb_regWrite}, 16'd0);
      idle();
      step();
      check_cnt("stall_cnt", 16'd3);

      // Flush beats stall on an incoming r2 write
      instr(3'd2, 2'b00, 16'h2222);
      bus.flush = 1'b1;
      bus.stall = 1'b1;
      step();
      check("flush_regwrite", {15'd0, bus.wb_regWrite}, 16'd0);
      check("flush_write_reg", {13'd0, bus.wb_write_reg}, 16'd0);
      idle();
      step();
      check_cnt("flush_cnt", 16'd3);

      // Reserved select
      instr(3'd1, 2'b11, 16'h7777);
      step();
      check("err_flag", {15'd0, bus.wb_err}, 16'd1);
      check("err_data", bus.mem_write_back, 16'h0000);
      idle();
      step();
      check("err_one_cycle", {15'd0, bus.wb_err}, 16'd0);
      check_cnt("err_cnt", 16'd4);

      // Late load to r5, done three cycles after capture, flush ignored meanwhile
      instr(3'd5, 2'b01, 16'h0000);
      bus.mem_rd_pending = 1'b1;
      step();
      check("load_stall1", {15'd0, bus.wb_stall_req}, 16'd1);
      check("load_wait_nowrite", {15'd0, bus.wb_regWrite}, 16'd0);
      idle();
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      step();
      check("load_stall2", {15'd0, bus.wb_stall_req}, 16'd1);
      bus.flush = 1'b0;
      step();
      check("load_stall3", {15'd0, bus.wb_stall_req}, 16'd1);
      bus.mem_rd_done   = 1'b1;
      bus.mem_read_data = 16'hBEEF;
      step();
      check("load_release", {15'd0, bus.wb_stall_req}, 16'd0);
      check("load_regwrite", {15'd0, bus.wb_regWrite}, 16'd1);
      check("load_write_reg", {13'd0, bus.wb_write_reg}, 16'd5);
      check("load_data", bus.mem_write_back, 16'hBEEF);
      idle();
      step();
      check("load_one_cycle", {15'd0, bus.wb_regWrite}, 16'd0);
      check_cnt("load_cnt", 16'd5);

      // Load with data returned in the capture cycle
      instr(3'd6, 2'b01, 16'h0000);
      bus.mem_rd_pending = 1'b1;
      bus.mem_rd_done    = 1'b1;
      bus.mem_read_data  = 16'h0F0F;
      step();
      check("fast_load_nostall", {15'd0, bus.wb_stall_req}, 16'd0);
      check("fast_load_data", bus.mem_write_back, 16'h0F0F);
      check("fast_load_regwrite", {15'd0, bus.wb_regWrite}, 16'd1);

      // HALT then further writes
      idle();
      bus.mem_valid = 1'b1;
      bus.mem_halt  = 1'b1;
      step();
      check("halt_retiring", {15'd0, bus.halted}, 16'd0);
      instr(3'd7, 2'b00, 16'h4321);
      step();
      check("halted_set", {15'd0, bus.halted}, 16'd1);
      check("halted_stall_req", {15'd0, bus.wb_stall_req}, 16'd1);
      check("halted_nowrite", {15'd0, bus.wb_regWrite}, 16'd0);
      bus.flush = 1'b1;
      step();
      check("halted_sticky", {15'd0, bus.halted}, 16'd1);
      check("halted_nowrite2", {15'd0, bus.wb_regWrite}, 16'd0);
      check_cnt("halt_cnt", 16'd7);
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_clears_halt", {15'd0, bus.halted}, 16'd0);
      check("rst_clears_stall", {15'd0, bus.wb_stall_req}, 16'd0);
      check_cnt("rst_clears_cnt", 16'd0);

      // Reset abandons a pending load; later rd_done ignored
      instr(3'd5, 2'b01, 16'h0000);
      bus.mem_rd_pending = 1'b1;
      step();
      check("abandon_wait", {15'd0, bus.wb_stall_req}, 16'd1);
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.mem_rd_done   = 1'b1;
      bus.mem_read_data = 16'hDEAD;
      step();
      check("abandon_nowrite", {15'd0, bus.wb_regWrite}, 16'd0);
      check("abandon_nostall", {15'd0, bus.wb_stall_req}, 16'd0);
      check("abandon_data", bus.mem_write_back, 16'h0000);

      // r7 write allowed
      instr(3'd7, 2'b00, 16'h4321);
      step();
      check("r7_regwrite", {15'd0, bus.wb_regWrite}, 16'd1);
      check("r7_write_reg", {13'd0, bus.wb_write_reg}, 16'd7);
      check("r7_data", bus.mem_write_back, 16'h4321);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
